// File: rtl/id_queue.sv
// id_queue: decodes RV32I instructions as they are accepted and buffers the records in a DEPTH-entry FIFO.
// Optional Zicsr decode is compiled in when the ID_ZICSR_EN macro is defined.
module id_queue #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              rd_we_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [3:0]        op_class_o,
  output logic [2:0]        funct3_o,
  output logic              funct7b5_o,
  output logic              illegal_o,
  output logic [11:0]       csr_addr_o,
  output logic              csr_we_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] CLS_NONE     = 4'd0;
  localparam logic [3:0] CLS_LUI      = 4'd1;
  localparam logic [3:0] CLS_AUIPC    = 4'd2;
  localparam logic [3:0] CLS_JAL      = 4'd3;
  localparam logic [3:0] CLS_JALR     = 4'd4;
  localparam logic [3:0] CLS_BRANCH   = 4'd5;
  localparam logic [3:0] CLS_LOAD     = 4'd6;
  localparam logic [3:0] CLS_STORE    = 4'd7;
  localparam logic [3:0] CLS_OP_IMM   = 4'd8;
  localparam logic [3:0] CLS_OP       = 4'd9;
  localparam logic [3:0] CLS_MISC_MEM = 4'd10;
  localparam logic [3:0] CLS_SYSTEM   = 4'd11;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [6:0]  F7_ZERO     = 7'b0000000;
  localparam logic [6:0]  F7_ALT      = 7'b0100000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              rd_we;
    logic [XLEN-1:0]   imm;
    logic [3:0]        op_class;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              illegal;
    logic [11:0]       csr_addr;
    logic              csr_we;
  } rec_t;

  logic [6:0]         opcode_s;
  logic [2:0]         funct3_s;
  logic [6:0]         funct7_s;
  logic [3:0]         cls_s;
  logic               ill_s;
  logic               use_rs1_s;
  logic               use_rs2_s;
  logic               use_rd_s;
  logic               csr_s;
  logic signed [31:0] imm32_s;
  rec_t               rec_s;
  rec_t               head_s;

  rec_t               mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;
  logic               push_s;
  logic               pop_s;

  // Instruction decode: classify, select operands and build the 32-bit immediate.
  always_comb begin
    opcode_s  = inst[6:0];
    funct3_s  = inst[14:12];
    funct7_s  = inst[31:25];
    cls_s     = CLS_NONE;
    ill_s     = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    csr_s     = 1'b0;
    imm32_s   = 32'sd0;
    case (opcode_s)
      OPC_LUI: begin
        cls_s    = CLS_LUI;
        use_rd_s = 1'b1;
        imm32_s  = {inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        cls_s    = CLS_AUIPC;
        use_rd_s = 1'b1;
        imm32_s  = {inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        cls_s    = CLS_JAL;
        use_rd_s = 1'b1;
        imm32_s  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        cls_s     = CLS_JALR;
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
        imm32_s   = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_BRANCH: begin
        cls_s     = CLS_BRANCH;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm32_s   = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        ill_s     = (funct3_s == 3'b010) || (funct3_s == 3'b011);
      end
      OPC_LOAD: begin
        cls_s     = CLS_LOAD;
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
        imm32_s   = {{20{inst[31]}}, inst[31:20]};
        ill_s     = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
      end
      OPC_STORE: begin
        cls_s     = CLS_STORE;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        imm32_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ill_s     = (funct3_s > 3'b010);
      end
      OPC_OP_IMM: begin
        cls_s     = CLS_OP_IMM;
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
        imm32_s   = {{20{inst[31]}}, inst[31:20]};
        // Shift-immediates reuse the upper immediate bits as a funct7 qualifier.
        if (funct3_s == 3'b001) begin
          ill_s = (funct7_s != F7_ZERO);
        end else if (funct3_s == 3'b101) begin
          ill_s = (funct7_s != F7_ZERO) && (funct7_s != F7_ALT);
        end else begin
          ill_s = 1'b0;
        end
      end
      OPC_OP: begin
        cls_s     = CLS_OP;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        use_rd_s  = 1'b1;
        if (funct7_s == F7_ZERO) begin
          ill_s = 1'b0;
        end else if (funct7_s == F7_ALT) begin
          ill_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
        end else begin
          ill_s = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        cls_s = CLS_MISC_MEM;
      end
      OPC_SYSTEM: begin
        cls_s = CLS_SYSTEM;
        if ((inst == INST_ECALL) || (inst == INST_EBREAK)) begin
          ill_s = 1'b0;
        end else begin
`ifdef ID_ZICSR_EN
          if ((funct3_s != 3'b000) && (funct3_s != 3'b100)) begin
            csr_s    = 1'b1;
            use_rd_s = 1'b1;
            // Immediate CSR forms carry a zero-extended uimm in the rs1 field.
            if (funct3_s[2]) begin
              imm32_s = {27'd0, inst[19:15]};
            end else begin
              use_rs1_s = 1'b1;
            end
          end else begin
            ill_s = 1'b1;
          end
`else
          ill_s = 1'b1;
`endif
        end
      end
      default: begin
        ill_s = 1'b1;
      end
    endcase
    if (inst[1:0] != 2'b11) begin
      ill_s = 1'b1;
    end else begin
      ill_s = ill_s;
    end
  end

  // Record assembly: an illegal instruction keeps only its PC and raw funct fields.
  always_comb begin
    rec_s          = '0;
    rec_s.addr     = inst_addr;
    rec_s.funct3   = funct3_s;
    rec_s.funct7b5 = inst[30];
    rec_s.illegal  = ill_s;
    if (!ill_s) begin
      rec_s.op_class = cls_s;
      rec_s.rs1      = use_rs1_s ? inst[19:15] : 5'd0;
      rec_s.rs2      = use_rs2_s ? inst[24:20] : 5'd0;
      rec_s.rd       = use_rd_s ? inst[11:7] : 5'd0;
      rec_s.rd_we    = use_rd_s && (inst[11:7] != 5'd0);
      rec_s.imm      = XLEN'(imm32_s);
      rec_s.csr_addr = csr_s ? inst[31:20] : 12'd0;
      rec_s.csr_we   = csr_s && ((funct3_s[1:0] == 2'b01) || (inst[19:15] != 5'd0));
    end else begin
      rec_s.op_class = CLS_NONE;
    end
  end

  assign in_ready  = (count_r != FULL_CNT);
  assign out_valid = (count_r != '0);
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready && !flush;

  // FIFO pointers and occupancy; flush clears everything and discards that cycle's traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Record storage, written with the decoded record at push time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= rec_s;
    end
  end

  // Head presentation, forced to zero while the queue is empty.
  always_comb begin
    head_s = '0;
    if (out_valid) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '0;
    end
  end

  assign inst_addr_o = head_s.addr;
  assign rs1_addr_o  = head_s.rs1;
  assign rs2_addr_o  = head_s.rs2;
  assign rd_addr_o   = head_s.rd;
  assign rd_we_o     = head_s.rd_we;
  assign imm_o       = head_s.imm;
  assign op_class_o  = head_s.op_class;
  assign funct3_o    = head_s.funct3;
  assign funct7b5_o  = head_s.funct7b5;
  assign illegal_o   = head_s.illegal;
  assign csr_addr_o  = head_s.csr_addr;
  assign csr_we_o    = head_s.csr_we;

endmodule

// File: tb/tb_id_queue.sv
// Bench for id_queue: table of hand-decoded instructions, scoreboard of expected head records,
// plus latency, backpressure, flush and asynchronous-reset sequences. Honours ID_ZICSR_EN.
module tb_id_queue;
  localparam int DEPTH = 4;
  localparam int NV    = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  logic        in_ready, out_valid, rd_we_o, funct7b5_o, illegal_o, csr_we_o;
  logic [31:0] inst_addr_o, imm_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [3:0]  op_class_o;
  logic [2:0]  funct3_o;
  logic [11:0] csr_addr_o;

  logic        b_in_ready, b_out_valid, b_rd_we, b_f7b5, b_illegal, b_csr_we;
  logic [31:0] b_inst_addr;
  logic [63:0] b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_class;
  logic [2:0]  b_f3;
  logic [11:0] b_csr_addr;

  id_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .inst_addr(inst_addr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .inst_addr_o(inst_addr_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .imm_o(imm_o), .op_class_o(op_class_o),
    .funct3_o(funct3_o), .funct7b5_o(funct7b5_o), .illegal_o(illegal_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o)
  );

  id_queue #(.XLEN(64), .ADDR_W(32), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .inst(inst),
    .inst_addr(inst_addr), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .inst_addr_o(b_inst_addr), .rs1_addr_o(b_rs1), .rs2_addr_o(b_rs2),
    .rd_addr_o(b_rd), .rd_we_o(b_rd_we), .imm_o(b_imm), .op_class_o(b_class),
    .funct3_o(b_f3), .funct7b5_o(b_f7b5), .illegal_o(b_illegal),
    .csr_addr_o(b_csr_addr), .csr_we_o(b_csr_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
    logic [11:0] csr;
    logic        cwe;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] addr;
  } exp_t;

  vec_t vt [NV];
  vec_t vnone;
  exp_t sb [$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  function automatic vec_t mk(input logic [31:0] i, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic we, input logic [31:0] im,
                              input logic [3:0] c, input logic [2:0] f3, input logic f7,
                              input logic il, input logic [11:0] ca, input logic cw);
    vec_t r;
    r.inst = i; r.rs1 = s1; r.rs2 = s2; r.rd = d; r.we = we; r.imm = im;
    r.cls = c; r.f3 = f3; r.f7b5 = f7; r.ill = il; r.csr = ca; r.cwe = cw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic any_rec();
    return |{inst_addr_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, imm_o, op_class_o,
             funct3_o, funct7b5_o, illegal_o, csr_addr_o, csr_we_o};
  endfunction

  task automatic cmp_head(input exp_t e);
    chk("addr", inst_addr_o, e.addr);
    chk("rs1", rs1_addr_o, e.v.rs1);
    chk("rs2", rs2_addr_o, e.v.rs2);
    chk("rd", rd_addr_o, e.v.rd);
    chk("rd_we", rd_we_o, e.v.we);
    chk("imm", imm_o, e.v.imm);
    chk("imm64", b_imm, 64'($signed(e.v.imm)));
    chk("class", op_class_o, e.v.cls);
    chk("funct3", funct3_o, e.v.f3);
    chk("funct7b5", funct7b5_o, e.v.f7b5);
    chk("illegal", illegal_o, e.v.ill);
    chk("csr_addr", csr_addr_o, e.v.csr);
    chk("csr_we", csr_we_o, e.v.cwe);
  endtask

  // One clock: drive at the falling edge, check against the scoreboard, update it for the next edge.
  task automatic cycle(input logic iv, input vec_t ev, input logic [31:0] addr,
                       input logic ordy, input logic fl, output logic acc);
    exp_t e;
    in_valid = iv; inst = ev.inst; inst_addr = addr; out_ready = ordy; flush = fl;
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, sb.size() != DEPTH);
    if (out_valid && sb.size() != 0) cmp_head(sb[0]);
    else if (!out_valid) chk("idle_zero", any_rec(), 1'b0);
    acc = iv && in_ready && !fl;
    if (!fl) begin
      if (out_valid && ordy && sb.size() != 0) void'(sb.pop_front());
      if (acc) begin
        e.v = ev; e.addr = addr;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    if (fl) sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; inst = 32'd0; inst_addr = 32'd0;
    vnone = mk(32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    vt[0]  = mk(32'hFFF10093, 5'd2, 5'd0, 5'd1, 1'b1, 32'hFFFFFFFF, 4'd8, 3'd0, 1'b1, 1'b0, 12'h0, 1'b0);
    vt[1]  = mk(32'hFE000EE3, 5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFFFFFC, 4'd5, 3'd0, 1'b1, 1'b0, 12'h0, 1'b0);
    vt[2]  = mk(32'h800002B7, 5'd0, 5'd0, 5'd5, 1'b1, 32'h80000000, 4'd1, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    vt[3]  = mk(32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd0, 1'b0, 1'b1, 12'h0, 1'b0);
`ifdef ID_ZICSR_EN
    vt[4]  = mk(32'h340110F3, 5'd2, 5'd0, 5'd1, 1'b1, 32'h0, 4'd11, 3'd1, 1'b0, 1'b0, 12'h340, 1'b1);
    vt[13] = mk(32'h3002D1F3, 5'd0, 5'd0, 5'd3, 1'b1, 32'h5, 4'd11, 3'd5, 1'b0, 1'b0, 12'h300, 1'b1);
    vt[18] = mk(32'h300022F3, 5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 4'd11, 3'd2, 1'b0, 1'b0, 12'h300, 1'b0);
`else
    vt[4]  = mk(32'h340110F3, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd1, 1'b0, 1'b1, 12'h0, 1'b0);
    vt[13] = mk(32'h3002D1F3, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd5, 1'b0, 1'b1, 12'h0, 1'b0);
    vt[18] = mk(32'h300022F3, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd2, 1'b0, 1'b1, 12'h0, 1'b0);
`endif
    vt[5]  = mk(32'h00000073, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd11, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    vt[6]  = mk(32'h00512423, 5'd2, 5'd5, 5'd0, 1'b0, 32'h8, 4'd7, 3'd2, 1'b0, 1'b0, 12'h0, 1'b0);
    vt[7]  = mk(32'h405201B3, 5'd4, 5'd5, 5'd3, 1'b1, 32'h0, 4'd9, 3'd0, 1'b1, 1'b0, 12'h0, 1'b0);
    vt[8]  = mk(32'h405261B3, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd6, 1'b1, 1'b1, 12'h0, 1'b0);
    vt[9]  = mk(32'h010000EF, 5'd0, 5'd0, 5'd1, 1'b1, 32'h10, 4'd3, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    vt[10] = mk(32'hFFF1A003, 5'd3, 5'd0, 5'd0, 1'b0, 32'hFFFFFFFF, 4'd6, 3'd2, 1'b1, 1'b0, 12'h0, 1'b0);
    vt[11] = mk(32'h0FF0000F, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd10, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0);
    vt[12] = mk(32'h00013083, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd3, 1'b0, 1'b1, 12'h0, 1'b0);
    vt[14] = mk(32'h40111093, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd1, 1'b1, 1'b1, 12'h0, 1'b0);
    vt[15] = mk(32'h40115093, 5'd2, 5'd0, 5'd1, 1'b1, 32'h401, 4'd8, 3'd5, 1'b1, 1'b0, 12'h0, 1'b0);
    vt[16] = mk(32'h00000011, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd0, 3'd0, 1'b0, 1'b1, 12'h0, 1'b0);
    vt[17] = mk(32'h00100073, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 4'd11, 3'd0, 1'b0, 1'b0, 12'h0, 1'b0);

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rec_zero", any_rec(), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single push into an empty queue appears at the head on the next cycle.
    cycle(1'b1, vt[0], 32'h100, 1'b0, 1'b0, acc);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_imm", imm_o, 32'hFFFFFFFF);
    cycle(1'b0, vnone, 32'h0, 1'b1, 1'b0, acc);

    // Backpressure: offer five with out_ready low; only four are taken and the head holds.
    idx = 1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, vt[idx], 32'h1000 + 32'(idx * 4), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("full_accepts", idx, 5);
    chk("full_hold", in_ready, 1'b0);

    // Stream the rest of the table with random execute stalls, then drain.
    for (int b = 0; b < 400 && idx < NV; b++) begin
      cycle(1'b1, vt[idx], 32'h1000 + 32'(idx * 4), ($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) idx++;
    end
    chk("stream_done", idx, NV);
    for (int b = 0; b < 50 && sb.size() != 0; b++) cycle(1'b0, vnone, 32'h0, 1'b1, 1'b0, acc);
    chk("drained", sb.size(), 0);

    // Flush with three queued and a push offered: everything is discarded.
    for (int k = 5; k < 8; k++) cycle(1'b1, vt[k], 32'h2000 + 32'(k * 4), 1'b0, 1'b0, acc);
    cycle(1'b1, vt[9], 32'h2100, 1'b0, 1'b1, acc);
    chk("flush_empty", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, vnone, 32'h0, 1'b1, 1'b0, acc);

    // Asynchronous reset in the middle of a drain.
    for (int k = 15; k < 18; k++) cycle(1'b1, vt[k], 32'h3000 + 32'(k * 4), 1'b0, 1'b0, acc);
    cycle(1'b0, vnone, 32'h0, 1'b1, 1'b0, acc);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_rec_zero", any_rec(), 1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cycle(1'b1, vt[2], 32'h4000, 1'b0, 1'b0, acc);
    cycle(1'b0, vnone, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, vnone, 32'h0, 1'b1, 1'b0, acc);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/id_queue.md
Name: id_queue

Overview:
- Registered, parametrised successor to the combinational RV32I decode stage.
- Accepts fetched instructions over a valid/ready handshake and decodes each one on entry.
- Buffers the decoded records in a DEPTH-entry FIFO and presents the head record to execute over a second valid/ready handshake.
- Adds sign-extension to XLEN, illegal-instruction detection, flush, and optional Zicsr decode.

Parameters:
- XLEN, 32, register/immediate width; legal values are 32 and 64.
- ADDR_W, 32, instruction address width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- inst  in  32  instruction word.
- inst_addr  in  ADDR_W  instruction PC.
- flush  in  1  synchronous discard of all entries.
- out_valid  out  1  head record valid.
- out_ready  in  1  execute consumes head.
- inst_addr_o  out  ADDR_W  head PC.
- rs1_addr_o  out  5  source register 1.
- rs2_addr_o  out  5  source register 2.
- rd_addr_o  out  5  destination register.
- rd_we_o  out  1  destination write enable.
- imm_o  out  XLEN  sign-extended immediate.
- op_class_o  out  4  instruction class.
- funct3_o  out  3  inst[14:12].
- funct7b5_o  out  1  inst[30].
- illegal_o  out  1  illegal instruction.
- csr_addr_o  out  12  CSR address.
- csr_we_o  out  1  CSR write enable.

Behaviour:
- Reset (rst=0, asynchronous): pointers and count = 0; out_valid=0; in_ready=1; all record outputs = 0.
- in_ready = (count != DEPTH).
  - Push on in_valid & in_ready.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - When full, no push occurs even if a pop happens in that cycle.
- out_valid = (count != 0). Latency: an instruction accepted in cycle N is presented at the head in cycle N+1 when the queue was empty.
- Head outputs are stable while out_valid=1 and out_ready=0. When out_valid=0, all record outputs are 0.
- Pointers wrap modulo DEPTH.
- flush=1 takes priority: count and pointers clear at the next edge, and any push or pop in that cycle is discarded.
- Decode is combinational on inst, and the result is stored at push time.
- op_class encoding: 0 illegal/none, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP, 10 MISC_MEM, 11 SYSTEM.
- Register addresses:
  - rs1 = inst[19:15] for JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and register-form CSR ops; otherwise 0.
  - rs2 = inst[24:20] for BRANCH, STORE, OP; otherwise 0.
  - rd = inst[11:7] for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and CSR ops; otherwise 0.
- rd_we_o = 1 when rd is used and rd != 0.
- Immediates (all sign-extended to XLEN):
  - I-type for JALR, LOAD, OP_IMM.
  - S-type for STORE.
  - B-type for BRANCH, with bit 0 = 0.
  - J-type for JAL, with bit 0 = 0.
  - U-type {inst[31:12], 12'b0} for LUI and AUIPC.
  - All other classes: 0.
- illegal_o=1 for any of:
  - inst[1:0] != 2'b11;
  - unknown opcode;
  - BRANCH funct3 of 010 or 011;
  - LOAD funct3 of 011, 110 or 111;
  - STORE funct3 > 010;
  - shift-immediate (funct3 001/101) with inst[31:25] not 0000000 or 0100000 (or 0100000 with funct3=001);
  - OP funct7 not 0000000, or 0100000 with funct3 other than 000/101;
  - SYSTEM other than ECALL/EBREAK when the optional feature is absent.
- An illegal record has op_class=0, rd_we=0, all register addresses 0, imm 0, and keeps inst_addr.
- FENCE/FENCE.I decode as class 10 with no register use.

Optional Feature:
- Macro: ID_ZICSR_EN.
- When defined:
  - SYSTEM funct3 001/010/011/101/110/111 are legal.
  - csr_addr_o = inst[31:20].
  - For funct3[2]=1, imm_o = zero-extended inst[19:15] and rs1 = 0.
  - csr_we_o = 1 for funct3[1:0]=01, or when inst[19:15] != 0.
- When undefined: csr_addr_o=0 and csr_we_o=0 always; those encodings are illegal. The ports exist in both builds.

Test Plan:
- Empty queue, push 0xFFF10093 (addi x1,x2,-1) → next cycle: out_valid=1, rs1=2, rd=1, rd_we=1, imm=0xFFFFFFFF, class=8.
- DEPTH=4, out_ready=0, push 5 back-to-back → in_ready=0 after the 4th accept; 5th held. Then out_ready=1 → 4 records emerge in order, in_ready rises the cycle after the first pop.
- Push 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, class=5, rd_we=0. Push 0x800002B7 (lui x5) with XLEN=64 → imm=0xFFFFFFFF80000000.
- 3 entries queued, flush=1 with in_valid=1 → next cycle: out_valid=0, count=0, the pushed instruction is lost.
- Push 0x00000000 → illegal_o=1, class=0, rd_we=0. Push 0x340110F3 (csrrw x1,mscratch,x2):
  - with ID_ZICSR_EN: csr_addr=0x340, csr_we=1, rd=1;
  - without: illegal_o=1.
- rst driven low mid-drain, asynchronously → out_valid=0 and in_ready=1 without waiting for a clock edge.
